// File: rtl/watch_timekeeper_pkg.sv
// Shared encodings for the watch time base: seven-segment codes, mode and
// write-port state encodings, and the digit-to-segment lookup.
package watch_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // "00-00-00" with byte 0 (leftmost character) in the least significant byte
  localparam logic [63:0] PAT_ZERO = 64'hC0C0_BFC0_C0BF_C0C0;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HR  = 2'd1,
    MODE_SET_MIN = 2'd2
  } mode_e;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_BUSY = 1'b1
  } wr_state_e;

  function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    bcd_to_seg = SEG_0;
      4'd1:    bcd_to_seg = SEG_1;
      4'd2:    bcd_to_seg = SEG_2;
      4'd3:    bcd_to_seg = SEG_3;
      4'd4:    bcd_to_seg = SEG_4;
      4'd5:    bcd_to_seg = SEG_5;
      4'd6:    bcd_to_seg = SEG_6;
      4'd7:    bcd_to_seg = SEG_7;
      4'd8:    bcd_to_seg = SEG_8;
      4'd9:    bcd_to_seg = SEG_9;
      default: bcd_to_seg = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/watch_timekeeper_counter.sv
// Two-digit BCD counter wrapping at TERM; carry pulses on the increment that wraps.
module bcd_mod_counter #(
  parameter int TERM = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       carry
);

  localparam logic [3:0] TERM_T = 4'(TERM / 10);
  localparam logic [3:0] TERM_U = 4'(TERM % 10);

  logic [3:0] tens_q, tens_d;
  logic [3:0] units_q, units_d;
  logic       at_term;

  assign at_term = (tens_q == TERM_T) && (units_q == TERM_U);
  assign carry   = inc & at_term;
  assign tens    = tens_q;
  assign units   = units_q;

  always_comb begin
    tens_d  = tens_q;
    units_d = units_q;
    if (clr) begin
      tens_d  = 4'd0;
      units_d = 4'd0;
    end else if (inc) begin
      if (at_term) begin
        tens_d  = 4'd0;
        units_d = 4'd0;
      end else if (units_q == 4'd9) begin
        tens_d  = tens_q + 4'd1;
        units_d = 4'd0;
      end else begin
        units_d = units_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tens_q  <= 4'd0;
      units_q <= 4'd0;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

endmodule

// File: rtl/watch_timekeeper.sv
// Watch time base: BCD HH:MM:SS with two-button setting, "HH-MM-SS" segment
// rendering and an Avalon-MM write master pushing each changed pattern word.
module watch_timekeeper
  import watch_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int SYNC_STG = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_mode,
  input  logic        btn_inc,
  output logic [3:0]  m_address,
  output logic        m_write,
  output logic [63:0] m_writedata,
  output logic [7:0]  m_byteenable,
  input  logic        m_waitrequest,
  output logic [23:0] time_bcd,
  output logic [1:0]  set_mode
);

  localparam int               PRE_W    = $clog2(CLK_HZ);
  localparam logic [PRE_W-1:0] PRE_TERM = PRE_W'(CLK_HZ - 1);
  localparam logic [PRE_W-1:0] PRE_HALF = PRE_W'(CLK_HZ / 2 - 1);

  // Button conditioning: index 0 = mode, index 1 = inc
  logic [1:0] btn_raw, btn_pulse;
  assign btn_raw = {btn_inc, btn_mode};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic [SYNC_STG-1:0] sync_q, sync_d;
    logic                prev_q;
    assign sync_d = {sync_q[SYNC_STG-2:0], btn_raw[gi]};
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync_q <= '0;
        prev_q <= 1'b0;
      end else begin
        sync_q <= sync_d;
        prev_q <= sync_q[SYNC_STG-1];
      end
    end
    assign btn_pulse[gi] = sync_q[SYNC_STG-1] & ~prev_q;
  end

  mode_e            mode_q;
  logic             mode_pulse, inc_pulse, leave_set_min, run;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick, blink_q, blink_d;

  assign mode_pulse    = btn_pulse[0];
  assign inc_pulse     = btn_pulse[1] & ~btn_pulse[0];
  assign run           = (mode_q == MODE_RUN);
  assign leave_set_min = mode_pulse & (mode_q == MODE_SET_MIN);
  assign tick          = (pre_q == PRE_TERM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= MODE_RUN;
    end else if (mode_pulse) begin
      case (mode_q)
        MODE_RUN:    mode_q <= MODE_SET_HR;
        MODE_SET_HR: mode_q <= MODE_SET_MIN;
        default:     mode_q <= MODE_RUN;
      endcase
    end
  end

  // Time counters; carries only ripple while running
  logic [3:0] sec_t, sec_u, min_t, min_u, hr_t, hr_u;
  logic       sec_carry, min_carry, hr_carry_unused;
  logic       sec_inc, min_inc, hr_inc;

  assign sec_inc = run & tick;
  assign min_inc = (run & sec_carry) | ((mode_q == MODE_SET_MIN) & inc_pulse);
  assign hr_inc  = (run & min_carry) | ((mode_q == MODE_SET_HR) & inc_pulse);

  bcd_mod_counter #(.TERM(59)) u_sec (
    .clk(clk), .reset(reset), .inc(sec_inc), .clr(leave_set_min),
    .tens(sec_t), .units(sec_u), .carry(sec_carry)
  );
  bcd_mod_counter #(.TERM(59)) u_min (
    .clk(clk), .reset(reset), .inc(min_inc), .clr(1'b0),
    .tens(min_t), .units(min_u), .carry(min_carry)
  );
  bcd_mod_counter #(.TERM(23)) u_hr (
    .clk(clk), .reset(reset), .inc(hr_inc), .clr(1'b0),
    .tens(hr_t), .units(hr_u), .carry(hr_carry_unused)
  );

  logic [63:0] pattern_q, pattern_d;

  always_comb begin
    pre_d = tick ? '0 : pre_q + PRE_W'(1);
    if (leave_set_min) pre_d = '0;
    blink_d = blink_q ^ (tick | (pre_q == PRE_HALF));

    pattern_d = {bcd_to_seg(sec_u), bcd_to_seg(sec_t), SEG_DASH,
                 bcd_to_seg(min_u), bcd_to_seg(min_t), SEG_DASH,
                 bcd_to_seg(hr_u),  bcd_to_seg(hr_t)};
    if (blink_q && mode_q == MODE_SET_HR)  pattern_d[15:0]  = {SEG_BLANK, SEG_BLANK};
    if (blink_q && mode_q == MODE_SET_MIN) pattern_d[39:24] = {SEG_BLANK, SEG_BLANK};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q     <= '0;
      blink_q   <= 1'b0;
      pattern_q <= PAT_ZERO;
    end else begin
      pre_q     <= pre_d;
      blink_q   <= blink_d;
      pattern_q <= pattern_d;
    end
  end

  // pending tracks "pattern_q differs from what the slave last accepted";
  // last_sent resets to an impossible pattern so the first word always goes out
  wr_state_e   wr_state_q;
  logic        m_write_q, pending_q;
  logic [63:0] m_writedata_q, last_sent_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_state_q    <= WR_IDLE;
      m_write_q     <= 1'b0;
      m_writedata_q <= PAT_ZERO;
      last_sent_q   <= '0;
      pending_q     <= 1'b1;
    end else begin
      pending_q <= (pattern_d != last_sent_q);
      case (wr_state_q)
        WR_IDLE: begin
          if (pending_q) begin
            m_writedata_q <= pattern_q;
            m_write_q     <= 1'b1;
            wr_state_q    <= WR_BUSY;
          end
        end
        WR_BUSY: begin
          if (!m_waitrequest) begin
            m_write_q   <= 1'b0;
            last_sent_q <= m_writedata_q;
            pending_q   <= (pattern_d != m_writedata_q);
            wr_state_q  <= WR_IDLE;
          end
        end
      endcase
    end
  end

  assign m_address    = 4'h0;
  assign m_byteenable = 8'hFF;
  assign m_write      = m_write_q;
  assign m_writedata  = m_writedata_q;
  assign time_bcd     = {hr_t, hr_u, min_t, min_u, sec_t, sec_u};
  assign set_mode     = mode_q;

endmodule

// File: tb/tb_watch_timekeeper.sv
// Directed bench for watch_timekeeper at CLK_HZ=10: one tick every 10 cycles,
// blink high after cycles 5..9 of each second; outputs sampled on the falling edge.
module tb_watch_timekeeper;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        btn_mode = 1'b0;
  logic        btn_inc = 1'b0;
  logic        m_waitrequest = 1'b0;
  logic [3:0]  m_address;
  logic        m_write;
  logic [63:0] m_writedata;
  logic [7:0]  m_byteenable;
  logic [23:0] time_bcd;
  logic [1:0]  set_mode;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int act = 0;
  int base = 0;
  int wr_count = 0;
  int w0 = 0;
  logic [63:0] last_data = '0;
  logic [63:0] prev_data = '0;
  logic        busy_seen;

  always #5 clk = ~clk;

  watch_timekeeper #(.CLK_HZ(10), .SYNC_STG(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_mode     (btn_mode),
    .btn_inc      (btn_inc),
    .m_address    (m_address),
    .m_write      (m_write),
    .m_writedata  (m_writedata),
    .m_byteenable (m_byteenable),
    .m_waitrequest(m_waitrequest),
    .time_bcd     (time_bcd),
    .set_mode     (set_mode)
  );

  always @(posedge clk) begin
    if (reset && m_write && !m_waitrequest) begin
      prev_data = last_data;
      last_data = m_writedata;
      wr_count++;
      $display("write %0d data=%h", wr_count, m_writedata);
    end
  end

  function automatic logic [7:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 8'hC0;  4'd1: seg = 8'hF9;  4'd2: seg = 8'hA4;
      4'd3: seg = 8'hB0;  4'd4: seg = 8'h99;  4'd5: seg = 8'h92;
      4'd6: seg = 8'h82;  4'd7: seg = 8'hF8;  4'd8: seg = 8'h80;
      4'd9: seg = 8'h90;  default: seg = 8'hFF;
    endcase
  endfunction

  // byte 0 (LSB) is the hour tens character
  function automatic logic [63:0] pat(input logic [23:0] t);
    pat = {seg(t[3:0]), seg(t[7:4]), 8'hBF, seg(t[11:8]), seg(t[15:12]),
           8'hBF, seg(t[19:16]), seg(t[23:20])};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic step_mod(input int r);
    do step(); while (cyc % 10 != r);
  endtask

  // Action lands on the 3rd rising edge after the press starts
  task automatic press(input logic m, input logic i);
    btn_mode = m;
    btn_inc  = i;
    repeat (3) step();
    act = cyc;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_time", time_bcd, 24'h000000);
    check_eq("rst_mode", set_mode, 2'd0);
    check_eq("rst_write", m_write, 1'b0);
    check_eq("rst_data", m_writedata, 64'hC0C0BFC0C0BFC0C0);
    reset = 1'b1;
    cyc = 0;

    step();
    check_eq("first_write", m_write, 1'b1);
    check_eq("first_data", m_writedata, 64'hC0C0BFC0C0BFC0C0);
    check_eq("address", m_address, 4'h0);
    check_eq("byteenable", m_byteenable, 8'hFF);
    step();
    check_eq("first_done", m_write, 1'b0);
    step();
    check_eq("first_count", wr_count, 1);

    step_to(25);
    check_eq("run_2s", time_bcd, 24'h000002);
    press(1'b1, 1'b0);
    check_eq("mode_sethr", set_mode, 2'd1);
    repeat (3) press(1'b0, 1'b1);
    check_eq("hr_inc3", time_bcd, 24'h030002);
    step_mod(4);
    check_eq("blink0_data", m_writedata, pat(24'h030002));
    step_mod(9);
    check_eq("blink1_hr", m_writedata[15:0], 16'hFFFF);
    check_eq("blink1_rest", m_writedata[63:16], pat(24'h030002) >> 16);
    press(1'b1, 1'b0);
    check_eq("mode_setmin", set_mode, 2'd2);
    check_eq("frozen", time_bcd, 24'h030002);
    press(1'b1, 1'b0);
    check_eq("mode_run", set_mode, 2'd0);
    check_eq("sec_cleared", time_bcd, 24'h030000);

    press(1'b1, 1'b0);
    repeat (20) press(1'b0, 1'b1);
    check_eq("hr_23", time_bcd, 24'h230000);
    press(1'b0, 1'b1);
    check_eq("hr_wrap", time_bcd, 24'h000000);
    repeat (23) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    repeat (59) press(1'b0, 1'b1);
    check_eq("min_59", time_bcd, 24'h235900);
    press(1'b0, 1'b1);
    check_eq("min_wrap", time_bcd, 24'h230000);
    repeat (59) press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    base = act;
    check_eq("preset", time_bcd, 24'h235900);

    step_to(base + 595);
    check_eq("t_235959", time_bcd, 24'h235959);
    w0 = wr_count;
    step_to(base + 605);
    check_eq("day_wrap", time_bcd, 24'h000000);
    check_eq("wrap_writes", wr_count - w0, 1);
    check_eq("wrap_data", last_data, pat(24'h000000));

    step_to(base + 606);
    m_waitrequest = 1'b1;
    w0 = wr_count;
    step_to(base + 613);
    for (int k = 0; k < 14; k++) begin
      check_eq("stall_write", m_write, 1'b1);
      check_eq("stall_data", m_writedata, pat(24'h000001));
      if (k == 13) begin
        check_eq("stall_count", wr_count - w0, 0);
        m_waitrequest = 1'b0;
      end
      step();
    end
    step_to(base + 629);
    check_eq("post_stall_cnt", wr_count - w0, 2);
    check_eq("post_stall_1st", prev_data, pat(24'h000001));
    check_eq("post_stall_2nd", last_data, pat(24'h000002));

    press(1'b1, 1'b1);
    check_eq("both_mode", set_mode, 2'd1);
    check_eq("both_time", time_bcd, 24'h000003);

    btn_inc = 1'b1;
    #1 btn_inc = 1'b0;
    #1 btn_inc = 1'b1;
    #1 btn_inc = 1'b0;
    #1 btn_inc = 1'b1;
    repeat (3) step();
    btn_inc = 1'b0;
    repeat (3) step();
    check_eq("bounce_once", time_bcd, 24'h010003);
    #1 btn_inc = 1'b1;
    #2 btn_inc = 1'b0;
    repeat (6) step();
    check_eq("glitch_ignored", time_bcd, 24'h010003);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check_eq("back_run", set_mode, 2'd0);
    check_eq("back_time", time_bcd, 24'h010000);

    m_waitrequest = 1'b1;
    busy_seen = 1'b0;
    for (int k = 0; k < 30 && !busy_seen; k++) begin
      step();
      busy_seen = m_write;
    end
    check_eq("busy_seen", busy_seen, 1'b1);
    reset = 1'b0;
    #1;
    check_eq("async_drop", m_write, 1'b0);
    check_eq("async_time", time_bcd, 24'h000000);
    check_eq("async_mode", set_mode, 2'd0);
    @(negedge clk);
    reset = 1'b1;
    m_waitrequest = 1'b0;
    cyc = 0;
    step();
    check_eq("rerelease_write", m_write, 1'b1);
    check_eq("rerelease_data", m_writedata, pat(24'h000000));
    check_eq("rerelease_time", time_bcd, 24'h000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
